// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared constants and types for the MIPS-subset multicycle CPU
//               (multiply/divide state encoding, funct codes, memToReg codes).
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Multiply/divide sequencer state encoding
  localparam logic [2:0] c_MD_IDLE    = 3'd0;
  localparam logic [2:0] c_MD_MULT    = 3'd1;
  localparam logic [2:0] c_MD_DIV     = 3'd2;
  localparam logic [2:0] c_MD_DIV_FIX = 3'd3;
  localparam logic [2:0] c_MD_FINISH  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE    = c_MD_IDLE,
    S_MULT    = c_MD_MULT,
    S_DIV     = c_MD_DIV,
    S_DIV_FIX = c_MD_DIV_FIX,
    S_FINISH  = c_MD_FINISH
  } md_state_t;

  // Which kind of operation is in flight; decides what FINISH commits
  typedef enum logic [1:0] {
    OP_MULT     = 2'd0,
    OP_DIV      = 2'd1,
    OP_DIV_ZERO = 2'd2
  } md_op_t;

  // R-type funct codes handled around the HI/LO registers
  localparam logic [5:0] c_FUNCT_MULT = 6'h18;
  localparam logic [5:0] c_FUNCT_DIV  = 6'h1A;
  localparam logic [5:0] c_FUNCT_MFHI = 6'h10;
  localparam logic [5:0] c_FUNCT_MFLO = 6'h12;

  // memToReg mux select codes for reading HI and LO
  localparam logic [2:0] c_MEMTOREG_HI = 3'd3;
  localparam logic [2:0] c_MEMTOREG_LO = 3'd4;

endpackage
`default_nettype wire

// File: rtl/booth_step.sv
`default_nettype none
// ============================================================================
// Module      : booth_step
// Description : One combinational radix-2 Booth iteration: conditional
//               add/subtract of the multiplicand followed by an arithmetic
//               right shift of {acc, Q, q-1}.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]   q,
  input  logic               q_m1,
  input  logic [WIDTH-1:0]   mcand,
  output logic [2*WIDTH:0]   step_out
);

  // Sum is kept one bit wider so the shifted-in sign is the true sign even
  // when acc +/- mcand overflows WIDTH bits (e.g. mcand = most negative).
  logic [WIDTH:0] w_sum;

  // Booth recode of {q0, q-1}, then shift: {sum, q} is exactly the shifted
  // {acc', Q', q-1'} because the extra sum bit supplies the replicated sign.
  always_comb begin
    w_sum = {acc[WIDTH-1], acc};
    case ({q[0], q_m1})
      2'b01:   w_sum = {acc[WIDTH-1], acc} + {mcand[WIDTH-1], mcand};
      2'b10:   w_sum = {acc[WIDTH-1], acc} - {mcand[WIDTH-1], mcand};
      default: w_sum = {acc[WIDTH-1], acc};
    endcase
    step_out = {w_sum, q};
  end

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : Multicycle signed multiply (radix-2 Booth) and divide
//               (restoring) unit with HI/LO result registers.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             mult_start,
  input  logic             div_start,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);
  import cpu_pkg::*;

  localparam int                 c_CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(WIDTH);

  md_state_t          r_state;
  md_state_t          w_state_next;
  md_op_t             r_op;
  logic [c_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_acc;    // Booth accumulator / divider remainder
  logic [WIDTH-1:0]   r_q;      // multiplier / dividend-then-quotient
  logic               r_qm1;
  logic [WIDTH-1:0]   r_opnd;   // multiplicand / |divisor|
  logic               r_sign_a;
  logic               r_sign_b;

  logic               w_acc_mult;
  logic               w_acc_div;
  logic               w_acc_dz;
  logic [2*WIDTH:0]   w_booth_next;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_rem_shift;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_next;

  booth_step #(.WIDTH(WIDTH)) u_booth_step (
    .acc      (r_acc),
    .q        (r_q),
    .q_m1     (r_qm1),
    .mcand    (r_opnd),
    .step_out (w_booth_next)
  );

  // Operand magnitudes and one restoring-division step; the shifted
  // remainder is one bit wider since it can reach 2*|B|-1.
  always_comb begin
    w_abs_a     = A[WIDTH-1] ? -A : A;
    w_abs_b     = B[WIDTH-1] ? -B : B;
    w_rem_shift = {r_acc, r_q[WIDTH-1]};
    w_ge        = (w_rem_shift >= {1'b0, r_opnd});
    w_rem_next  = w_ge ? (w_rem_shift[WIDTH-1:0] - r_opnd) : w_rem_shift[WIDTH-1:0];
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic and accept strobes; multiply wins over divide
  always_comb begin
    w_state_next = r_state;
    w_acc_mult   = 1'b0;
    w_acc_div    = 1'b0;
    w_acc_dz     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mult_start) begin
          w_acc_mult   = 1'b1;
          w_state_next = S_MULT;
        end else if (div_start) begin
          if (B != '0) begin
            w_acc_div    = 1'b1;
            w_state_next = S_DIV;
          end else begin
            w_acc_dz     = 1'b1;
            w_state_next = S_FINISH;
          end
        end
      end
      S_MULT:    if (r_cnt == c_CNT_W'(1)) w_state_next = S_FINISH;
      S_DIV:     if (r_cnt == c_CNT_W'(1)) w_state_next = S_DIV_FIX;
      S_DIV_FIX: w_state_next = S_FINISH;
      S_FINISH:  w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // Datapath, result registers and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op     <= OP_MULT;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_qm1    <= 1'b0;
      r_opnd   <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      HI       <= '0;
      LO       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_acc_mult) begin
            r_op     <= OP_MULT;
            r_opnd   <= A;
            r_q      <= B;
            r_acc    <= '0;
            r_qm1    <= 1'b0;
            r_cnt    <= c_CNT_INIT;
            busy     <= 1'b1;
            div_zero <= 1'b0;
          end else if (w_acc_div) begin
            r_op     <= OP_DIV;
            r_q      <= w_abs_a;
            r_opnd   <= w_abs_b;
            r_sign_a <= A[WIDTH-1];
            r_sign_b <= B[WIDTH-1];
            r_acc    <= '0;
            r_qm1    <= 1'b0;
            r_cnt    <= c_CNT_INIT;
            busy     <= 1'b1;
            div_zero <= 1'b0;
          end else if (w_acc_dz) begin
            r_op     <= OP_DIV_ZERO;
            busy     <= 1'b1;
            div_zero <= 1'b0;
          end
        end
        S_MULT: begin
          {r_acc, r_q, r_qm1} <= w_booth_next;
          r_cnt               <= r_cnt - 1'b1;
        end
        S_DIV: begin
          r_acc <= w_rem_next;
          r_q   <= {r_q[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt - 1'b1;
        end
        S_DIV_FIX: begin
          // Quotient truncates toward zero; remainder follows the dividend
          r_q   <= (r_sign_a ^ r_sign_b) ? -r_q : r_q;
          r_acc <= r_sign_a ? -r_acc : r_acc;
        end
        S_FINISH: begin
          busy <= 1'b0;
          done <= 1'b1;
          if (r_op == OP_DIV_ZERO) begin
            div_zero <= 1'b1;
          end else begin
            HI <= r_acc;
            LO <= r_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Self-checking bench for mult_div_unit: directed vector table,
//               multi-cycle corner sequences and random ops against a
//               plain-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] A, B;
  logic         mult_start, div_start;
  logic [W-1:0] HI, LO;
  logic         busy, done, div_zero;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    bit          is_div;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t vecs[12];

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .A          (A),
    .B          (B),
    .mult_start (mult_start),
    .div_start  (div_start),
    .HI         (HI),
    .LO         (LO),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present a request for one accept edge; returns #1 after that edge
  task automatic issue(input bit is_div, input logic [31:0] a, input logic [31:0] b);
    A          = a;
    B          = b;
    mult_start = !is_div;
    div_start  = is_div;
    @(posedge clk);
    #1;
    mult_start = 1'b0;
    div_start  = 1'b0;
  endtask

  // Wait (bounded) for done; checks latency and busy behaviour
  task automatic wait_done(input string name, input int exp_lat);
    int n = 0;
    bit busy_ok = 1'b1;
    while (!done && n < 100) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    check({name, " latency"}, 64'(n), 64'(exp_lat));
    check({name, " busy"}, {63'd0, busy_ok}, 64'd1);
    check({name, " busy@done"}, {63'd0, busy}, 64'd0);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int lat;
    lat = !v.is_div ? 33 : ((v.b == 32'd0) ? 1 : 34);
    issue(v.is_div, v.a, v.b);
    wait_done(name, lat);
    check({name, " HI:LO"}, {HI, LO}, {v.hi, v.lo});
    check({name, " div_zero"}, {63'd0, div_zero}, {63'd0, v.dz});
    @(posedge clk);
    #1;
    check({name, " done pulse"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    logic [31:0] m_hi, m_lo;
    logic        m_dz;
    int          done_cnt, done_lat;
    logic [63:0] done_res;

    vecs[0]  = '{0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0};
    vecs[2]  = '{1, 32'h00000005, 32'h00000000, 32'h3FFFFFFF, 32'h00000001, 1'b1};
    vecs[3]  = '{0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[4]  = '{1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[5]  = '{1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[6]  = '{1, 32'h00000005, 32'h00000000, 32'h00000000, 32'h80000000, 1'b1};
    vecs[7]  = '{0, 32'h00000003, 32'h00000004, 32'h00000000, 32'h0000000C, 1'b0};
    vecs[8]  = '{1, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0};
    vecs[9]  = '{1, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[10] = '{1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, 1'b0};
    vecs[11] = '{0, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000, 1'b0};

    reset      = 1'b1;
    A          = '0;
    B          = '0;
    mult_start = 1'b0;
    div_start  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset HI:LO", {HI, LO}, 64'd0);
    check("reset flags", {61'd0, busy, done, div_zero}, 64'd0);
    reset = 1'b0;

    // Directed table
    for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back: second start presented in the done cycle
    issue(0, 32'h7FFFFFFF, 32'h7FFFFFFF);
    wait_done("b2b first", 33);
    check("b2b first HI:LO", {HI, LO}, 64'h3FFFFFFF_00000001);
    issue(0, 32'h80000000, 32'h80000000);
    wait_done("b2b second", 33);
    check("b2b second HI:LO", {HI, LO}, 64'h40000000_00000000);
    @(posedge clk);
    #1;

    // Reset in the middle of a multiply
    issue(0, 32'h00000005, 32'h00000005);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midreset HI:LO", {HI, LO}, 64'd0);
    check("midreset flags", {61'd0, busy, done, div_zero}, 64'd0);
    reset = 1'b0;
    issue(0, 32'd3, 32'd4);
    wait_done("post-reset mult", 33);
    check("post-reset HI:LO", {HI, LO}, 64'h00000000_0000000C);
    @(posedge clk);
    #1;

    // Simultaneous starts, then a stray div_start while busy
    A          = 32'd6;
    B          = 32'd3;
    mult_start = 1'b1;
    div_start  = 1'b1;
    @(posedge clk);
    #1;
    mult_start = 1'b0;
    div_start  = 1'b0;
    done_cnt   = 0;
    done_lat   = 0;
    done_res   = '0;
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk);
      #1;
      if (n == 5) div_start = 1'b1;
      if (n == 7) div_start = 1'b0;
      if (done) begin
        done_cnt++;
        done_lat = n;
        done_res = {HI, LO};
      end
    end
    check("both-start done count", 64'(done_cnt), 64'd1);
    check("both-start latency", 64'(done_lat), 64'd33);
    check("both-start HI:LO", done_res, 64'h00000000_00000012);

    // Random ops against the arithmetic model
    m_hi = 32'h0;
    m_lo = 32'h12;
    for (int i = 0; i < 40; i++) begin
      vec_t   v;
      longint pa, pb, pr, qr;
      int     sel;
      v.is_div = 1'($urandom_range(0, 1));
      v.a      = $urandom;
      sel      = $urandom_range(0, 7);
      case (sel)
        0:       v.b = 32'd0;
        1:       v.b = 32'($urandom_range(1, 20));
        2:       v.b = -32'($urandom_range(1, 20));
        3:       v.a = 32'h80000000;
        default: v.b = $urandom;
      endcase
      if (sel == 3) v.b = $urandom;
      pa = longint'(signed'(v.a));
      pb = longint'(signed'(v.b));
      if (!v.is_div) begin
        pr   = pa * pb;
        m_hi = pr[63:32];
        m_lo = pr[31:0];
        m_dz = 1'b0;
      end else if (v.b == 32'd0) begin
        m_dz = 1'b1;
      end else begin
        qr   = pa / pb;
        pr   = pa % pb;
        m_lo = qr[31:0];
        m_hi = pr[31:0];
        m_dz = 1'b0;
      end
      v.hi = m_hi;
      v.lo = m_lo;
      v.dz = m_dz;
      run_vec(v, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multicycle signed multiply/divide unit for the MIPS-subset multicycle CPU. Sits downstream of the control unit, which pulses a start for MULT or DIV (R-type, funct 0x18/0x1A).
- The control unit holds in a wait state until `done`. Results sit in the HI/LO registers, which the memToReg mux reads for MFHI/MFLO.
- Implementation: radix-2 Booth multiplier and restoring divider, one iteration per clock.

Parameters:
WIDTH, 32, operand width; HI/LO width; iteration count.

Ports:
clk  in  1  system clock, all state updates on posedge
reset  in  1  synchronous, active-high reset
A  in  WIDTH  operand rs (multiplicand / dividend), sampled on accept edge
B  in  WIDTH  operand rt (multiplier / divisor), sampled on accept edge
mult_start  in  1  request signed multiply; level-sampled in IDLE only
div_start  in  1  request signed divide; level-sampled in IDLE only
HI  out  WIDTH  mult: product[63:32]; div: remainder
LO  out  WIDTH  mult: product[31:0]; div: quotient
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse
div_zero  out  1  last completed DIV had divisor 0

Behaviour:
- Reset (sync, any state, including mid-operation):
  - state=IDLE; HI=0, LO=0, busy=0, done=0, div_zero=0; counter=0; internal operand/accumulator regs cleared.
- States: IDLE, MULT, DIV, DIV_FIX, FINISH.
- IDLE, accept edge E0:
  - mult_start=1 -> latch A, B; acc=0; Booth bit q-1=0; counter=WIDTH; busy=1; div_zero=0; go to MULT.
  - else div_start=1 with B!=0 -> latch |A|, |B| and both signs; rem=0; counter=WIDTH; busy=1; div_zero=0; go to DIV.
  - else div_start=1 with B==0 -> go to FINISH immediately with div_zero pending; HI/LO not modified.
  - mult_start and div_start both high -> MULT wins; div request dropped.
- MULT: one Booth step per edge.
  - Pair {q0,q-1}: 01 -> acc+=A; 10 -> acc-=A.
  - Then arithmetic right shift of {acc,Q,q-1}; counter-1.
  - Edge E32 performs the last step; state -> FINISH.
- DIV: one restoring step per edge.
  - Shift {rem,Q} left 1; trial=rem-|B|.
  - trial>=0 -> rem=trial, Q[0]=1; else Q[0]=0. counter-1.
  - Edge E32 -> DIV_FIX.
- DIV_FIX (edge E33): sign correction.
  - Quotient negated if signs of A and B differ.
  - Remainder takes the sign of the dividend.
  - Results held internally; state -> FINISH.
- FINISH edge (mult E33, div E34, div-by-zero E1):
  - HI/LO <= result (unchanged for div-by-zero); div_zero <= 1 only for div-by-zero.
  - done=1 and busy=0 for exactly the following cycle; state -> IDLE.
- Cycle after the done cycle: done=0. A start sampled in that cycle is accepted, so back-to-back operations are allowed.
- busy=1 from E0 until the FINISH edge. Starts while busy are ignored; no queuing.
- HI/LO hold their value between operations and change only at the FINISH edge or on reset.
- Arithmetic:
  - Product is full 2·WIDTH signed; no overflow flag.
  - Quotient truncates toward zero.
  - 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0 (wraps, no trap).
- Counter width is $clog2(WIDTH)+1.

Decomposition:
- Shared package cpu_pkg:
  - mult_div state encoding localparams.
  - funct constants MULT=6'h18, DIV=6'h1A, MFHI=6'h10, MFLO=6'h12.
  - memToReg select codes for HI and LO.
- One combinational sub-module, booth_step:
  - Inputs: acc, Q, q-1, multiplicand.
  - Output: next {acc,Q,q-1}.
  - Unit-testable on its own.
- Divider step stays inline.

Test Plan:
1. mult_start, A=7, B=0xFFFFFFFD (-3) -> at E33 HI=0xFFFFFFFF, LO=0xFFFFFFEB; done high exactly 1 cycle; busy high for cycles E0..E33.
2. mult, A=B=0x7FFFFFFF -> HI=0x3FFFFFFF, LO=0x00000001; then immediate back-to-back mult 0x80000000*0x80000000 -> HI=0x40000000, LO=0.
3. div_start, A=0xFFFFFFF9 (-7), B=2 -> at E34 LO=0xFFFFFFFD, HI=0xFFFFFFFF; div_zero=0. Then 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
4. Preload HI/LO via a mult, then div_start A=5, B=0 -> done and div_zero at E1; HI/LO unchanged. Next accepted start clears div_zero.
5. Assert reset at cycle 10 of a mult -> next cycle all outputs 0, busy=0. A following mult 3*4 -> LO=12, HI=0 at E33.
6. mult_start and div_start high together with A=6, B=3 -> multiply result LO=18. Pulse div_start mid-operation -> ignored; single done pulse.
